// File: rtl/ntt_core_engine_if.sv
// rtl/ntt_core_engine_if.sv - operand/control/result bundle for one NTT butterfly engine
interface ntt_core_engine_if;
  logic [3:0]  log_m;
  logic [9:0]  i;
  logic [1:0]  mode;
  logic [8:0]  read_address;
  logic        upper_write_enable;
  logic [8:0]  upper_write_address;
  logic [59:0] upper_data_input;
  logic        lower_write_enable;
  logic [8:0]  lower_write_address;
  logic [59:0] lower_data_input;
  logic [29:0] r1;
  logic [29:0] r2;
  logic [29:0] r3;
  logic [29:0] r4;

  modport master (
    output log_m, i, mode, read_address,
    output upper_write_enable, upper_write_address, upper_data_input,
    output lower_write_enable, lower_write_address, lower_data_input,
    input  r1, r2, r3, r4
  );

  modport slave (
    input  log_m, i, mode, read_address,
    input  upper_write_enable, upper_write_address, upper_data_input,
    input  lower_write_enable, lower_write_address, lower_data_input,
    output r1, r2, r3, r4
  );
endinterface

// File: rtl/ntt_core_engine.sv
// rtl/ntt_core_engine.sv - 3-stage radix-2 CT/GS butterfly, pointwise multiply and readout PE
module ntt_core_engine #(
  parameter int MOD_INDEX      = 0,
  parameter int CORE_INDEX     = 0,
  parameter int LOG_CORE_COUNT = 5
) (
  input logic             clk,
  input logic             rst_n,
  ntt_core_engine_if.slave bus
);
  localparam logic [63:0] Q = (MOD_INDEX == 1) ? 64'd754974721 :
                              (MOD_INDEX == 2) ? 64'd469762049 :
                              (MOD_INDEX == 3) ? 64'd167772161 : 64'd998244353;
  localparam logic [63:0] G = (MOD_INDEX == 1) ? 64'd11 : 64'd3;
  localparam logic [30:0] Q31 = Q[30:0];

  // Elaboration-time modular exponentiation used to build the twiddle ROM.
  function automatic logic [63:0] pow_mod(input logic [63:0] base, input logic [63:0] e);
    logic [63:0] r;
    logic [63:0] b;
    r = 64'd1;
    b = base % Q;
    for (int n = 0; n < 64; n++) begin
      if (e[n]) r = (r * b) % Q;
      b = (b * b) % Q;
    end
    return r;
  endfunction

  localparam logic [63:0] OMEGA = pow_mod(G, (Q - 64'd1) / 64'd2048);
  // floor(2^60/q) never underestimates the quotient by more than one, so one correction suffices.
  localparam logic [63:0] MU    = 64'h1000_0000_0000_0000 / Q;
  localparam logic [33:0] MU34  = MU[33:0];

  function automatic logic [29:0] add_mod(input logic [29:0] x, input logic [29:0] y);
    logic [30:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q31) s = s - Q31;
    return 30'(s);
  endfunction

  function automatic logic [29:0] sub_mod(input logic [29:0] x, input logic [29:0] y);
    logic [30:0] s;
    s = {1'b0, x} - {1'b0, y};
    if (x < y) s = s + Q31;
    return 30'(s);
  endfunction

  function automatic logic [29:0] mul_mod(input logic [29:0] x, input logic [29:0] y);
    logic [59:0] p;
    logic [93:0] pm;
    logic [33:0] qh;
    logic [59:0] qq;
    logic [30:0] r;
    p  = 60'(x) * 60'(y);
    pm = 94'(p) * 94'(MU34);
    qh = 34'(pm >> 60);
    qq = 60'(qh) * 60'(Q);
    r  = 31'(p - qq);
    if (r >= Q31) r = r - Q31;
    return 30'(r);
  endfunction

  logic [29:0] rom [2048];
  for (genvar t = 0; t < 2048; t++) begin : g_rom
    localparam logic [63:0] W = pow_mod(OMEGA, 64'(t));
    assign rom[t] = W[29:0];
  end

  logic [59:0] mem_a [512];
  logic [59:0] mem_b [512];

  // Upper memory write port; no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (bus.upper_write_enable) mem_a[bus.upper_write_address] <= bus.upper_data_input;
  end

  // Lower memory write port.
  always_ff @(posedge clk) begin
    if (bus.lower_write_enable) mem_b[bus.lower_write_address] <= bus.lower_data_input;
  end

  logic [31:0] j_d;
  logic [31:0] mask_d;
  logic [10:0] t_d;
  logic [10:0] tinv_d;
  logic [29:0] w_d;

  // Twiddle exponent for this core's butterfly; inverse mode reads the conjugate entry.
  always_comb begin
    j_d    = (32'(bus.i) << LOG_CORE_COUNT) | 32'(CORE_INDEX);
    mask_d = (32'd1 << bus.log_m) - 32'd1;
    t_d    = 11'd0;
    if (bus.log_m <= 4'd10) t_d = 11'((j_d & mask_d) << (4'd10 - bus.log_m));
    tinv_d = 11'd0 - t_d;
    w_d    = (bus.mode == 2'd1) ? rom[tinv_d] : rom[t_d];
  end

  logic [59:0] s1_a_q, s1_b_q;
  logic [29:0] s1_w_q;
  logic [1:0]  s1_mode_q;

  // Stage 1: read-first memory data, twiddle and controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_w_q    <= '0;
      s1_mode_q <= '0;
    end else begin
      s1_a_q    <= mem_a[bus.read_address];
      s1_b_q    <= mem_b[bus.read_address];
      s1_w_q    <= w_d;
      s1_mode_q <= bus.mode;
    end
  end

  logic [29:0] x0_d, y0_d, x1_d, y1_d, p0_d, p1_d;

  // Multiplier operand steering: GS subtracts before the twiddle product.
  always_comb begin
    x0_d = s1_a_q[29:0];
    y0_d = s1_b_q[29:0];
    x1_d = s1_a_q[59:30];
    y1_d = s1_b_q[59:30];
    if (s1_mode_q == 2'd0) begin
      x0_d = s1_w_q;
      x1_d = s1_w_q;
    end else if (s1_mode_q == 2'd1) begin
      x0_d = sub_mod(s1_a_q[29:0], s1_b_q[29:0]);
      x1_d = sub_mod(s1_a_q[59:30], s1_b_q[59:30]);
      y0_d = s1_w_q;
      y1_d = s1_w_q;
    end
    p0_d = mul_mod(x0_d, y0_d);
    p1_d = mul_mod(x1_d, y1_d);
  end

  logic [59:0] s2_a_q, s2_b_q;
  logic [29:0] s2_p0_q, s2_p1_q;
  logic [1:0]  s2_mode_q;

  // Stage 2: reduced products with operands carried alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_a_q    <= '0;
      s2_b_q    <= '0;
      s2_p0_q   <= '0;
      s2_p1_q   <= '0;
      s2_mode_q <= '0;
    end else begin
      s2_a_q    <= s1_a_q;
      s2_b_q    <= s1_b_q;
      s2_p0_q   <= p0_d;
      s2_p1_q   <= p1_d;
      s2_mode_q <= s1_mode_q;
    end
  end

  logic [29:0] r1_d, r2_d, r3_d, r4_d;

  // Final add/sub and result selection per mode.
  always_comb begin
    r1_d = s2_a_q[29:0];
    r2_d = s2_a_q[59:30];
    r3_d = s2_b_q[29:0];
    r4_d = s2_b_q[59:30];
    case (s2_mode_q)
      2'd0: begin
        r1_d = add_mod(s2_a_q[29:0], s2_p0_q);
        r2_d = sub_mod(s2_a_q[29:0], s2_p0_q);
        r3_d = add_mod(s2_a_q[59:30], s2_p1_q);
        r4_d = sub_mod(s2_a_q[59:30], s2_p1_q);
      end
      2'd1: begin
        r1_d = add_mod(s2_a_q[29:0], s2_b_q[29:0]);
        r2_d = s2_p0_q;
        r3_d = add_mod(s2_a_q[59:30], s2_b_q[59:30]);
        r4_d = s2_p1_q;
      end
      2'd2: begin
        r1_d = s2_p0_q;
        r2_d = s2_p1_q;
        r3_d = 30'd0;
        r4_d = 30'd0;
      end
      default: ;
    endcase
  end

  logic [29:0] r1_q, r2_q, r3_q, r4_q;

  // Stage 3: registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
      r4_q <= '0;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
      r4_q <= r4_d;
    end
  end

  assign bus.r1 = r1_q;
  assign bus.r2 = r2_q;
  assign bus.r3 = r3_q;
  assign bus.r4 = r4_q;
endmodule

// File: tb/tb_ntt_core_engine.sv
// tb/tb_ntt_core_engine.sv - scoreboard bench for ntt_core_engine (q=998244353, core 1 of 32)
module tb_ntt_core_engine;
  localparam longint Q = 64'sd998244353;
  localparam int CORE = 1;
  localparam int LOGC = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_core_engine_if bus();

  ntt_core_engine #(.MOD_INDEX(0), .CORE_INDEX(CORE), .LOG_CORE_COUNT(LOGC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int next_id = 0;
  longint omega;
  logic [59:0] ma [512];
  logic [59:0] mb [512];

  typedef struct {
    int due;
    int id;
    int prop;
    logic [29:0] e1, e2, e3, e4;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  function automatic longint mulm(input longint a, input longint b);
    return (a * b) % Q;
  endfunction
  function automatic longint addm(input longint a, input longint b);
    return (a + b) % Q;
  endfunction
  function automatic longint subm(input longint a, input longint b);
    return (a - b + Q) % Q;
  endfunction
  function automatic longint powm(input longint b, input longint e);
    longint r = 1;
    longint bb = b % Q;
    longint ee = e;
    while (ee > 0) begin
      if (ee % 2 == 1) r = mulm(r, bb);
      bb = mulm(bb, bb);
      ee = ee / 2;
    end
    return r;
  endfunction
  function automatic longint texp(input int lm, input int ii);
    longint j, k;
    if (lm > 10) return 0;
    j = (longint'(ii) << LOGC) | longint'(CORE);
    k = j % (longint'(1) << lm);
    return k << (10 - lm);
  endfunction
  function automatic logic [29:0] rc();
    return 30'($urandom % 32'd998244353);
  endfunction

  task automatic check(input string nm, input int id, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s id=%0d actual=%0d required=%0d", nm, id, act, req);
    end
  endtask

  task automatic drive_read(input logic [8:0] ra, input logic [1:0] md, input logic [3:0] lm,
                            input logic [9:0] ii, input int prop, input bit lit,
                            input logic [29:0] l1, input logic [29:0] l2,
                            input logic [29:0] l3, input logic [29:0] l4);
    exp_t e;
    longint a0, a1, b0, b1, t, w, wi, x1, x2, x3, x4;
    bus.read_address = ra;
    bus.mode = md;
    bus.log_m = lm;
    bus.i = ii;
    a0 = longint'(ma[ra][29:0]);
    a1 = longint'(ma[ra][59:30]);
    b0 = longint'(mb[ra][29:0]);
    b1 = longint'(mb[ra][59:30]);
    t  = texp(int'(lm), int'(ii));
    w  = powm(omega, t);
    wi = powm(omega, (2048 - t) % 2048);
    case (md)
      2'd0: begin
        x1 = addm(a0, mulm(w, b0)); x2 = subm(a0, mulm(w, b0));
        x3 = addm(a1, mulm(w, b1)); x4 = subm(a1, mulm(w, b1));
      end
      2'd1: begin
        x1 = addm(a0, b0); x2 = mulm(subm(a0, b0), wi);
        x3 = addm(a1, b1); x4 = mulm(subm(a1, b1), wi);
      end
      2'd2: begin
        x1 = mulm(a0, b0); x2 = mulm(a1, b1); x3 = 0; x4 = 0;
      end
      default: begin
        x1 = a0; x2 = a1; x3 = b0; x4 = b1;
      end
    endcase
    if (lit) begin
      e.e1 = l1; e.e2 = l2; e.e3 = l3; e.e4 = l4;
    end else begin
      e.e1 = x1[29:0]; e.e2 = x2[29:0]; e.e3 = x3[29:0]; e.e4 = x4[29:0];
    end
    e.due = cyc + 3;
    e.id = next_id;
    e.prop = prop;
    next_id++;
    sb.push_back(e);
  endtask

  task automatic model_read(input logic [8:0] ra, input logic [1:0] md,
                            input logic [3:0] lm, input logic [9:0] ii);
    drive_read(ra, md, lm, ii, 0, 1'b0, 30'd0, 30'd0, 30'd0, 30'd0);
  endtask

  task automatic drive_write(input bit upper, input logic [8:0] ad, input logic [59:0] d);
    if (upper) begin
      bus.upper_write_enable = 1'b1; bus.upper_write_address = ad; bus.upper_data_input = d;
      ma[ad] = d;
    end else begin
      bus.lower_write_enable = 1'b1; bus.lower_write_address = ad; bus.lower_data_input = d;
      mb[ad] = d;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    bus.upper_write_enable = 1'b0;
    bus.lower_write_enable = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_r1", -1, longint'(bus.r1), 0);
    check("rst_mid_r2", -1, longint'(bus.r2), 0);
    check("rst_mid_r3", -1, longint'(bus.r3), 0);
    check("rst_mid_r4", -1, longint'(bus.r4), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      model_read(9'(a), 2'd3, 4'd0, 10'd0);
      tick();
    end
  endtask

  // Scoreboard monitor: compares the head entry on its due cycle.
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      if (sb[0].due < cyc) begin
        mon_e = sb.pop_front();
        check("late", mon_e.id, longint'(cyc), longint'(mon_e.due));
      end else if (sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check("r1", mon_e.id, longint'(bus.r1), longint'(mon_e.e1));
        check("r2", mon_e.id, longint'(bus.r2), longint'(mon_e.e2));
        check("r3", mon_e.id, longint'(bus.r3), longint'(mon_e.e3));
        check("r4", mon_e.id, longint'(bus.r4), longint'(mon_e.e4));
        if (mon_e.prop == 1) begin
          check("w_squared", mon_e.id, mulm(longint'(bus.r1), longint'(bus.r1)), Q - 1);
          check("w_negated", mon_e.id, longint'(bus.r2), subm(0, longint'(bus.r1)));
        end
        if (mon_e.prop == 2)
          check("winv_times_w", mon_e.id, mulm(longint'(bus.r2), powm(omega, 512)), 1);
      end
    end
  end

  initial begin
    omega = powm(3, (Q - 1) / 2048);
    bus.log_m = '0; bus.i = '0; bus.mode = '0; bus.read_address = '0;
    bus.upper_write_enable = 1'b0; bus.upper_write_address = '0; bus.upper_data_input = '0;
    bus.lower_write_enable = 1'b0; bus.lower_write_address = '0; bus.lower_data_input = '0;
    for (int a = 0; a < 512; a++) begin
      ma[a] = '0;
      mb[a] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_r1", -1, longint'(bus.r1), 0);
    check("rst_r2", -1, longint'(bus.r2), 0);
    check("rst_r3", -1, longint'(bus.r3), 0);
    check("rst_r4", -1, longint'(bus.r4), 0);
    rst_n = 1'b1;
    tick();

    drive_write(1'b1, 9'd0, {30'd0, 30'd100});
    drive_write(1'b0, 9'd0, {30'd0, 30'd10});
    tick();
    drive_read(9'd0, 2'd3, 4'd0, 10'd0, 0, 1'b1, 30'd100, 30'd0, 30'd10, 30'd0);
    tick();
    drive_read(9'd0, 2'd0, 4'd0, 10'd0, 0, 1'b1, 30'd110, 30'd90, 30'd0, 30'd0);
    tick();
    drive_write(1'b1, 9'd2, {30'd54321, 30'd1});
    drive_write(1'b0, 9'd2, {30'd12345, 30'd10});
    tick();
    drive_read(9'd2, 2'd0, 4'd0, 10'd5, 0, 1'b1, 30'd11, 30'd998244344, 30'd66666, 30'd41976);
    tick();
    drive_read(9'd2, 2'd0, 4'd12, 10'd1023, 0, 1'b1, 30'd11, 30'd998244344, 30'd66666, 30'd41976);
    tick();
    drive_write(1'b1, 9'd1, {30'd1, 30'd100});
    drive_write(1'b0, 9'd1, {30'd1, 30'd10});
    tick();
    drive_read(9'd1, 2'd2, 4'd3, 10'd7, 0, 1'b1, 30'd1000, 30'd1, 30'd0, 30'd0);
    tick();

    drive_write(1'b1, 9'd3, 60'd0);
    drive_write(1'b0, 9'd3, {30'd0, 30'd1});
    tick();
    drive_read(9'd3, 2'd0, 4'd1, 10'd0, 1, 1'b0, 30'd0, 30'd0, 30'd0, 30'd0);
    tick();
    drive_write(1'b1, 9'd4, {30'd0, 30'd1});
    drive_write(1'b0, 9'd4, 60'd0);
    tick();
    drive_read(9'd4, 2'd1, 4'd1, 10'd0, 2, 1'b0, 30'd0, 30'd0, 30'd0, 30'd0);
    tick();

    drive_read(9'd0, 2'd3, 4'd0, 10'd0, 0, 1'b1, 30'd100, 30'd0, 30'd10, 30'd0);
    drive_write(1'b1, 9'd0, {30'd7, 30'd8});
    tick();
    drive_read(9'd0, 2'd3, 4'd0, 10'd0, 0, 1'b1, 30'd8, 30'd7, 30'd10, 30'd0);
    tick();

    for (int a = 0; a < 5; a++) begin
      model_read(9'(a), (a % 2 == 0) ? 2'd3 : 2'd0, 4'(a + 2), 10'($urandom));
      tick();
    end
    for (int a = 0; a < 4; a++) begin
      model_read(9'(a), 2'(a), 4'($urandom), 10'($urandom));
      tick();
    end

    for (int a = 5; a < 16; a++) begin
      drive_write(1'b1, 9'(a), {rc(), rc()});
      drive_write(1'b0, 9'(a), {rc(), rc()});
      tick();
    end

    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      model_read(9'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 10'($urandom));
      if ($urandom_range(0, 3) == 0) drive_write(1'b1, 9'($urandom_range(0, 15)), {rc(), rc()});
      if ($urandom_range(0, 3) == 0) drive_write(1'b0, 9'($urandom_range(0, 15)), {rc(), rc()});
      tick();
    end

    repeat (5) tick();
    check("drain", -1, longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
